// File: rtl/led_message_scroller_pkg.sv
// rtl/led_message_scroller_pkg.sv - shared constants and state encoding for the LED message scroller
package led_message_scroller_pkg;

    localparam int CHAR_W = 4;

    localparam logic [CHAR_W-1:0] CHAR_HYPHEN = 4'd10;
    localparam logic [CHAR_W-1:0] CHAR_F      = 4'd11;
    localparam logic [CHAR_W-1:0] CHAR_SPACE  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

endpackage

// File: rtl/led_message_scroller_scan_tick_gen.sv
// rtl/led_message_scroller_scan_tick_gen.sv - refresh prescaler and scanned digit index
module scan_tick_gen #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIG_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic             o_tick,
    output logic [DIG_W-1:0] o_digit_idx
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [DIG_W-1:0] r_digit_idx;
    logic [DIG_W-1:0] w_next_idx;
    logic             w_tick;

    assign w_tick      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_next_idx  = (r_digit_idx == DIG_W'(DIGITS - 1)) ? '0 : r_digit_idx + DIG_W'(1);
    assign o_tick      = w_tick;
    assign o_digit_idx = r_digit_idx;

    // Free-running slot counter; the wrap cycle is the tick
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Advance the scanned digit once per slot; reset parks on the leftmost digit so the first tick lands on digit 0
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit_idx <= DIG_W'(DIGITS - 1);
        end else if (w_tick) begin
            r_digit_idx <= w_next_idx;
        end
    end

endmodule

// File: rtl/led_message_scroller.sv
// rtl/led_message_scroller.sv - buffered message scroller driving a multiplexed display (LED_SCROLL_LOOP_EN: repeat forever)
module led_message_scroller
    import led_message_scroller_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int MSG_LEN     = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_wr_valid,
    input  logic [CHAR_W-1:0] i_wr_char,
    input  logic              i_wr_last,
    output logic              o_wr_ready,
    output logic [CHAR_W-1:0] o_char,
    output logic [DIGITS-1:0] o_an,
    output logic              o_busy,
    output logic              o_done
);

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int LEN_W = $clog2(MSG_LEN + 1);
    localparam int OFF_W = $clog2(MSG_LEN + DIGITS);
    localparam int FR_W  = $clog2(SCROLL_DIV + 1);
    localparam int AW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int VW    = ((OFF_W > DIG_W) ? OFF_W : DIG_W) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [LEN_W-1:0]  r_wr_ptr;
    logic [LEN_W-1:0]  w_wr_ptr_nxt;
    logic [LEN_W-1:0]  w_wr_pos;
    logic [OFF_W-1:0]  r_offset;
    logic [OFF_W-1:0]  w_offset_nxt;
    logic [OFF_W-1:0]  w_last_off;
    logic [FR_W-1:0]   r_frame;
    logic [FR_W-1:0]   w_frame_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic [CHAR_W-1:0] r_buf [MSG_LEN];
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_addr;

    logic              w_tick;
    logic [DIG_W-1:0]  w_digit_idx;
    logic [DIG_W-1:0]  w_next_idx;
    logic              w_frame_edge;

    logic [VW-1:0]     w_v;
    logic              w_in_win;
    logic [AW-1:0]     w_rd_addr;
    logic [CHAR_W-1:0] w_rd_data;
    logic [CHAR_W-1:0] w_char_nxt;
    logic [DIGITS-1:0] w_an_nxt;
    logic [CHAR_W-1:0] r_char;
    logic [DIGITS-1:0] r_an;

    scan_tick_gen #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DIG_W       (DIG_W)
    ) u_scan (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .o_tick      (w_tick),
        .o_digit_idx (w_digit_idx)
    );

    assign w_next_idx   = (w_digit_idx == DIG_W'(DIGITS - 1)) ? '0 : w_digit_idx + DIG_W'(1);
    assign w_frame_edge = w_tick && (w_next_idx == '0);
    assign w_last_off   = OFF_W'(r_len) + OFF_W'(DIGITS - 2);
    assign w_wr_addr    = AW'(w_wr_pos);

    assign o_wr_ready = (r_state != ST_SCROLL);
    assign o_busy     = (r_state == ST_SCROLL);
    assign o_done     = r_done;
    assign o_char     = r_char;
    assign o_an       = r_an;

    // Next-state: message capture, scroll stepping and end-of-scroll handling
    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_wr_ptr_nxt = r_wr_ptr;
        w_offset_nxt = r_offset;
        w_frame_nxt  = r_frame;
        w_done_nxt   = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_pos     = (r_state == ST_IDLE) ? '0 : r_wr_ptr;
        if (i_clear) begin
            w_state_nxt  = ST_IDLE;
            w_len_nxt    = '0;
            w_wr_ptr_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (i_wr_valid) begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = w_wr_pos + LEN_W'(1);
                        if (i_wr_last || (w_wr_pos == LEN_W'(MSG_LEN - 1))) begin
                            w_state_nxt  = ST_SCROLL;
                            w_len_nxt    = w_wr_pos + LEN_W'(1);
                            w_offset_nxt = '0;
                            w_frame_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (w_frame_edge) begin
                        if (r_frame == FR_W'(SCROLL_DIV - 1)) begin
                            w_frame_nxt = '0;
                            if (r_offset == w_last_off) begin
`ifdef LED_SCROLL_LOOP_EN
                                w_offset_nxt = '0;
`else
                                w_state_nxt  = ST_IDLE;
                                w_len_nxt    = '0;
                                w_wr_ptr_nxt = '0;
                                w_offset_nxt = '0;
                                w_done_nxt   = 1'b1;
`endif
                            end else begin
                                w_offset_nxt = r_offset + OFF_W'(1);
                            end
                        end else begin
                            w_frame_nxt = r_frame + FR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Display lookup for the digit about to be enabled, using the post-edge state so a step lands on its first slot;
    // the write bypass covers a single-character message whose only character is stored on this same edge
    always_comb begin
        w_v       = VW'(w_offset_nxt) - VW'(w_next_idx);
        w_in_win  = (VW'(w_offset_nxt) >= VW'(w_next_idx)) && (w_v < VW'(w_len_nxt));
        w_rd_addr = AW'(w_v);
        w_rd_data = (w_wr_en && (w_wr_addr == w_rd_addr)) ? i_wr_char : r_buf[w_rd_addr];
        w_char_nxt = CHAR_SPACE;
        if ((w_state_nxt == ST_SCROLL) && w_in_win) begin
            w_char_nxt = w_rd_data;
        end
        w_an_nxt = '1;
        w_an_nxt[w_next_idx] = 1'b0;
    end

    // Control registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_wr_ptr <= '0;
            r_offset <= '0;
            r_frame  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_offset <= w_offset_nxt;
            r_frame  <= w_frame_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Message buffer; contents survive clear and are simply overwritten by the next message
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr_en) begin
            r_buf[w_wr_addr] <= i_wr_char;
        end
    end

    // Anode and character outputs change only on slot boundaries
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_an   <= '1;
            r_char <= CHAR_SPACE;
        end else if (w_tick) begin
            r_an   <= w_an_nxt;
            r_char <= w_char_nxt;
        end
    end

endmodule
